// File: rtl/command_tag_credit_manager.sv
// Command tag and PSL credit manager: gates command issue on credits and free tags,
// recycles tags from responses and flags protocol errors. Optional statistics: CMD_TAG_STATS_EN.
module command_tag_credit_manager #(
  parameter int NUM_TAGS  = 64,
  parameter int TAG_WIDTH = 8,
  parameter int CNT_WIDTH = 9
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 enabled_in,
  input  logic [7:0]           croom_in,
  input  logic                 cmd_request_in,
  output logic                 cmd_ready_out,
  output logic                 cmd_grant_out,
  output logic [TAG_WIDTH-1:0] cmd_tag_out,
  input  logic                 response_valid_in,
  input  logic [TAG_WIDTH-1:0] response_tag_in,
  output logic [CNT_WIDTH-1:0] credits_out,
  output logic [CNT_WIDTH-1:0] in_flight_out,
  output logic                 drained_out,
  output logic                 error_out,
  output logic [31:0]          stat_issued_out,
  output logic [CNT_WIDTH-1:0] stat_max_inflight_out
);

  localparam int PTR_W = (NUM_TAGS > 1) ? $clog2(NUM_TAGS) : 1;
  localparam logic [PTR_W-1:0]     LAST_PTR  = PTR_W'(NUM_TAGS - 1);
  localparam logic [CNT_WIDTH-1:0] POOL_SIZE = CNT_WIDTH'(NUM_TAGS);
  localparam logic [TAG_WIDTH:0]   TAG_LIMIT = (TAG_WIDTH + 1)'(NUM_TAGS);

  typedef enum logic [1:0] {
    ST_DISABLED,
    ST_LOAD,
    ST_ACTIVE,
    ST_DRAIN
  } state_e;

  state_e               state_q;
  logic [CNT_WIDTH-1:0] credits_q, credits_d;
  logic [CNT_WIDTH-1:0] in_flight_q, in_flight_d;
  logic [CNT_WIDTH-1:0] free_count_q, free_count_d;
  logic [PTR_W-1:0]     head_q, head_d;
  logic [PTR_W-1:0]     tail_q, tail_d;
  logic [NUM_TAGS-1:0]  bitmap_q, bitmap_d;
  logic                 error_q, error_d;
  logic [TAG_WIDTH-1:0] fifo_q [NUM_TAGS];

  logic                 grant;
  logic                 rsp_in_range;
  logic                 rsp_legal;
  logic                 rsp_bad;
  logic [PTR_W-1:0]     rsp_idx;
  logic [PTR_W-1:0]     grant_idx;
  logic [CNT_WIDTH-1:0] croom_ext;
  logic [CNT_WIDTH-1:0] credits_load;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == LAST_PTR) ? '0 : p + PTR_W'(1);
  endfunction

  assign cmd_ready_out = (state_q == ST_ACTIVE) && (credits_q != '0) && (free_count_q != '0);
  assign grant         = cmd_request_in && cmd_ready_out;
  assign cmd_grant_out = grant;
  assign cmd_tag_out   = fifo_q[head_q];
  assign grant_idx     = cmd_tag_out[PTR_W-1:0];

  // A response only counts if its tag is in range and currently outstanding.
  assign rsp_idx      = response_tag_in[PTR_W-1:0];
  assign rsp_in_range = {1'b0, response_tag_in} < TAG_LIMIT;
  assign rsp_legal    = response_valid_in && rsp_in_range && bitmap_q[rsp_idx];
  assign rsp_bad      = response_valid_in && !rsp_legal;

  assign croom_ext    = CNT_WIDTH'(croom_in);
  assign credits_load = (croom_ext > POOL_SIZE) ? POOL_SIZE : croom_ext;

  assign credits_out   = credits_q;
  assign in_flight_out = in_flight_q;
  assign drained_out   = (state_q == ST_DRAIN) && (in_flight_q == '0);
  assign error_out     = error_q;

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    credits_d    = credits_q;
    in_flight_d  = in_flight_q;
    free_count_d = free_count_q;
    head_d       = head_q;
    tail_d       = tail_q;
    bitmap_d     = bitmap_q;
    error_d      = error_q | rsp_bad;

    if (grant) begin
      head_d              = ptr_inc(head_q);
      bitmap_d[grant_idx] = 1'b1;
    end
    if (rsp_legal) begin
      tail_d            = ptr_inc(tail_q);
      bitmap_d[rsp_idx] = 1'b0;
    end

    // Grant plus legal response in one cycle nets to no change in the counters.
    case ({grant, rsp_legal})
      2'b10: begin
        credits_d    = credits_q - CNT_WIDTH'(1);
        in_flight_d  = in_flight_q + CNT_WIDTH'(1);
        free_count_d = free_count_q - CNT_WIDTH'(1);
      end
      2'b01: begin
        credits_d    = credits_q + CNT_WIDTH'(1);
        in_flight_d  = in_flight_q - CNT_WIDTH'(1);
        free_count_d = free_count_q + CNT_WIDTH'(1);
      end
      default: ;
    endcase

    if (state_q == ST_LOAD) credits_d = credits_load;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= ST_DISABLED;
    end else begin
      case (state_q)
        ST_DISABLED: if (enabled_in) state_q <= ST_LOAD;
        ST_LOAD:                     state_q <= ST_ACTIVE;
        ST_ACTIVE:   if (!enabled_in) state_q <= ST_DRAIN;
        ST_DRAIN:    if (in_flight_q == '0) state_q <= ST_DISABLED;
        default:                     state_q <= ST_DISABLED;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clock) begin
    if (reset) begin
      credits_q    <= '0;
      in_flight_q  <= '0;
      free_count_q <= POOL_SIZE;
      head_q       <= '0;
      tail_q       <= '0;
      bitmap_q     <= '0;
      error_q      <= 1'b0;
      // NOTE: the free-list storage is reset on purpose: it must hold 0..NUM_TAGS-1 after reset.
      for (int i = 0; i < NUM_TAGS; i++) fifo_q[i] <= TAG_WIDTH'(i);
    end else begin
      credits_q    <= credits_d;
      in_flight_q  <= in_flight_d;
      free_count_q <= free_count_d;
      head_q       <= head_d;
      tail_q       <= tail_d;
      bitmap_q     <= bitmap_d;
      error_q      <= error_d;
      if (rsp_legal) fifo_q[tail_q] <= response_tag_in;
    end
  end

`ifdef CMD_TAG_STATS_EN
  logic [31:0]          issued_q;
  logic [CNT_WIDTH-1:0] max_inflight_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      issued_q       <= '0;
      max_inflight_q <= '0;
    end else begin
      if (grant) issued_q <= issued_q + 32'd1;
      if (in_flight_d > max_inflight_q) max_inflight_q <= in_flight_d;
    end
  end

  assign stat_issued_out       = issued_q;
  assign stat_max_inflight_out = max_inflight_q;
`else
  assign stat_issued_out       = '0;
  assign stat_max_inflight_out = '0;
`endif

endmodule

// File: tb/tb_command_tag_credit_manager.sv
// Scoreboard bench for command_tag_credit_manager: a queue/array model predicts each
// cycle's outputs; a separate monitor pops and compares them.
module tb_command_tag_credit_manager;

  localparam int NT = 64;
  localparam int TW = 8;
  localparam int CW = 9;

  localparam int M_OFF   = 0;
  localparam int M_LOAD  = 1;
  localparam int M_ACT   = 2;
  localparam int M_DRAIN = 3;

  logic          clk = 1'b0;
  logic          rst;
  logic          en;
  logic [7:0]    croom;
  logic          req;
  logic          rv;
  logic [TW-1:0] rtag;
  logic          ready_o;
  logic          grant_o;
  logic [TW-1:0] tag_o;
  logic [CW-1:0] credits_o;
  logic [CW-1:0] inflight_o;
  logic          drained_o;
  logic          error_o;
  logic [31:0]   st_issued_o;
  logic [CW-1:0] st_max_o;

  always #5 clk = ~clk;

  command_tag_credit_manager #(.NUM_TAGS(NT), .TAG_WIDTH(TW), .CNT_WIDTH(CW)) dut (
    .clock                 (clk),
    .reset                 (rst),
    .enabled_in            (en),
    .croom_in              (croom),
    .cmd_request_in        (req),
    .cmd_ready_out         (ready_o),
    .cmd_grant_out         (grant_o),
    .cmd_tag_out           (tag_o),
    .response_valid_in     (rv),
    .response_tag_in       (rtag),
    .credits_out           (credits_o),
    .in_flight_out         (inflight_o),
    .drained_out           (drained_o),
    .error_out             (error_o),
    .stat_issued_out       (st_issued_o),
    .stat_max_inflight_out (st_max_o)
  );

  typedef struct {
    bit ready;
    bit grant;
    int credits;
    int inflight;
    bit err;
    bit drained;
    int issued;
    int peak;
  } exp_t;

  exp_t exp_q[$];
  int   tag_q[$];
  int   checks   = 0;
  int   failures = 0;

  // Reference model: mode, free-tag queue, outstanding set and plain counters.
  int m_mode;
  int m_free[$];
  bit m_out[NT];
  int m_credits;
  int m_inflight;
  bit m_err;
  int m_issued;
  int m_peak;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_mode = M_OFF;
    m_free.delete();
    for (int i = 0; i < NT; i++) begin
      m_free.push_back(i);
      m_out[i] = 1'b0;
    end
    m_credits  = 0;
    m_inflight = 0;
    m_err      = 1'b0;
    m_issued   = 0;
    m_peak     = 0;
  endtask

  function automatic int pick_outstanding();
    int list[$];
    for (int i = 0; i < NT; i++) if (m_out[i]) list.push_back(i);
    if (list.size() == 0) return -1;
    return list[$urandom_range(list.size() - 1)];
  endfunction

  // Drive one cycle of inputs, record the expected outputs, then advance the model.
  task automatic step(input bit r, input bit e, input int cr, input bit rq,
                      input bit v, input int t, input bit chk);
    exp_t x;
    bit   rdy;
    bit   gnt;
    bit   legal;
    int   gt;
    int   old_inflight;
    @(negedge clk);
    rst   = r;
    en    = e;
    croom = cr[7:0];
    req   = rq;
    rv    = v;
    rtag  = t[TW-1:0];

    rdy = (m_mode == M_ACT) && (m_credits > 0) && (m_free.size() > 0);
    gnt = rq && rdy;
    x.ready    = rdy;
    x.grant    = gnt;
    x.credits  = m_credits;
    x.inflight = m_inflight;
    x.err      = m_err;
    x.drained  = (m_mode == M_DRAIN) && (m_inflight == 0);
`ifdef CMD_TAG_STATS_EN
    x.issued = m_issued;
    x.peak   = m_peak;
`else
    x.issued = 0;
    x.peak   = 0;
`endif
    if (chk) begin
      exp_q.push_back(x);
      if (gnt) tag_q.push_back(m_free[0]);
    end

    if (r) begin
      model_reset();
    end else begin
      old_inflight = m_inflight;
      legal = v && (t >= 0) && (t < NT) && m_out[t];
      if (v && !legal) m_err = 1'b1;
      if (gnt) begin
        gt = m_free.pop_front();
        m_out[gt] = 1'b1;
        m_issued++;
      end
      if (legal) begin
        m_free.push_back(t);
        m_out[t] = 1'b0;
      end
      if (m_mode == M_LOAD) m_credits = (cr > NT) ? NT : cr;
      else                  m_credits = m_credits + int'(legal) - int'(gnt);
      m_inflight = m_inflight + int'(gnt) - int'(legal);
      if (m_inflight > m_peak) m_peak = m_inflight;
      case (m_mode)
        M_OFF:   if (e) m_mode = M_LOAD;
        M_LOAD:  m_mode = M_ACT;
        M_ACT:   if (!e) m_mode = M_DRAIN;
        default: if (old_inflight == 0) m_mode = M_OFF;
      endcase
    end
  endtask

  // Monitor: compares each recorded cycle and pops a tag whenever the DUT grants.
  initial begin
    exp_t x;
    forever begin
      @(negedge clk);
      #2;
      if (exp_q.size() > 0) begin
        x = exp_q.pop_front();
        check("ready",     int'(ready_o),    int'(x.ready));
        check("grant",     int'(grant_o),    int'(x.grant));
        check("credits",   int'(credits_o),  x.credits);
        check("in_flight", int'(inflight_o), x.inflight);
        check("error",     int'(error_o),    int'(x.err));
        check("drained",   int'(drained_o),  int'(x.drained));
        check("stat_issued", int'(st_issued_o), x.issued);
        check("stat_max_inflight", int'(st_max_o), x.peak);
        if (grant_o) begin
          if (tag_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL grant_tag: got grant with tag %0d, expected no grant at %0t", tag_o, $time);
          end else begin
            check("grant_tag", int'(tag_o), tag_q.pop_front());
          end
        end
      end
    end
  end

  initial begin
    int t;
    bit e;
    rst = 1'b1; en = 1'b0; croom = '0; req = 1'b0; rv = 1'b0; rtag = '0;
    model_reset();

    step(1, 0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0, 1);

    // Credit limit: four grants (tags 0..3), then ready stays low.
    repeat (12) step(0, 1, 4, 1, 0, 0, 1);

    // Tag recycle: return tag 2, next grant comes from the FIFO head (tag 4).
    step(0, 1, 4, 0, 1, 2, 1);
    repeat (3) step(0, 1, 4, 1, 0, 0, 1);

    // Grant and legal response in the same cycle with one credit.
    step(0, 1, 4, 0, 1, 0, 1);
    step(0, 1, 4, 1, 1, 1, 1);
    step(0, 1, 4, 0, 0, 0, 1);

    // Double free of tag 3, then an out-of-range tag.
    step(0, 1, 4, 0, 1, 3, 1);
    step(0, 1, 4, 0, 1, 3, 1);
    step(0, 1, 4, 0, 1, 200, 1);
    step(0, 1, 4, 0, 0, 0, 1);

    // Drain: no grants after enable drops; re-enable mid-drain has no effect.
    repeat (3) step(0, 0, 4, 1, 0, 0, 1);
    step(0, 1, 4, 1, 0, 0, 1);
    for (int k = 0; k < 80 && m_inflight > 0; k++) begin
      t = pick_outstanding();
      step(0, 0, 4, 1, 1, t, 1);
    end
    repeat (4) step(0, 0, 4, 1, 0, 0, 1);

    // Reset mid-run with many outstanding tags; croom above pool size is clamped.
    repeat (14) step(0, 1, 200, 1, 0, 0, 1);
    step(1, 1, 200, 0, 0, 0, 1);
    step(0, 0, 200, 0, 0, 0, 1);
    repeat (5) step(0, 1, 200, 1, 0, 0, 1);

    // Randomised traffic.
    e = 1'b1;
    for (int n = 0; n < 4000; n++) begin
      bit r;
      bit v;
      int cr;
      r = ($urandom_range(999) == 0);
      if ($urandom_range(99) == 0) e = ~e;
      cr = ($urandom_range(3) == 0) ? $urandom_range(255) : $urandom_range(8);
      v = 1'b0;
      t = 0;
      if ($urandom_range(399) == 0) begin
        v = 1'b1;
        t = $urandom_range(255);
      end else if ($urandom_range(2) == 0) begin
        t = pick_outstanding();
        v = (t >= 0);
        if (t < 0) t = 0;
      end
      step(r, e, cr, ($urandom_range(3) != 0), v, t, 1);
    end

    repeat (3) step(0, 0, 0, 0, 0, 0, 1);
    @(negedge clk);
    #4;
    check("scoreboard_status_left", exp_q.size(), 0);
    check("scoreboard_tags_left",   tag_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
